// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier that borrows the core ALU
// one add per multiplier bit, stalling while the arbiter withholds the grant.
module alu_mul_seq #(
    parameter int WIDTH       = 16,
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    input  logic [WIDTH-1:0] alu_ret,
    input  logic             alu_carry,
    output logic [1:0]       dbg_state
);
    // Handshake: alu_req is held with stable operands until a cycle in which
    // alu_gnt is high; that cycle's alu_ret/alu_carry are consumed at its edge.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    mcand_d = op_a;
                    mq_d    = op_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    if (ZERO_BYPASS && ((op_a == '0) || (op_b == '0))) begin
                        mq_d    = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (alu_gnt) begin
                    // The carry becomes the top accumulator bit, so the 2W-bit
                    // {acc, mq} pair shifts right with no overflow.
                    acc_d = {alu_carry, alu_ret[WIDTH-1:1]};
                    mq_d  = {alu_ret[0], mq_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                prod_hi_d = acc_q;
                prod_lo_d = mq_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign alu_req   = (state_q == ST_RUN);
    assign alu_ctrl  = 3'b000;
    assign alu_src1  = alu_req ? acc_q : '0;
    assign alu_src2  = (alu_req && mq_q[0]) ? mcand_q : '0;
    assign prod_hi   = prod_hi_q;
    assign prod_lo   = prod_lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: latency, products, stalls, bypass, flush, reset.
module tb_alu_mul_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, flush = 1'b0, gnt = 1'b1;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic busy, done, alu_req, alu_carry;
  logic [W-1:0] prod_hi, prod_lo, alu_src1, alu_src2, alu_ret;
  logic [2:0] alu_ctrl;
  logic [1:0] dbg_state;

  logic start_nb = 1'b0;
  logic nb_busy, nb_done, nb_req, nb_carry;
  logic [W-1:0] nb_hi, nb_lo, nb_s1, nb_s2, nb_ret;
  logic [2:0] nb_ctrl;
  logic [1:0] nb_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural ALU adders, one per instance.
  assign {alu_carry, alu_ret} = {1'b0, alu_src1} + {1'b0, alu_src2};
  assign {nb_carry, nb_ret}   = {1'b0, nb_s1} + {1'b0, nb_s2};

  alu_mul_seq #(.WIDTH(W), .ZERO_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .prod_hi(prod_hi), .prod_lo(prod_lo), .alu_req(alu_req), .alu_gnt(gnt),
    .alu_ctrl(alu_ctrl), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_ret(alu_ret), .alu_carry(alu_carry), .dbg_state(dbg_state)
  );

  alu_mul_seq #(.WIDTH(W), .ZERO_BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .start(start_nb), .flush(1'b0),
    .op_a(op_a), .op_b(op_b), .busy(nb_busy), .done(nb_done),
    .prod_hi(nb_hi), .prod_lo(nb_lo), .alu_req(nb_req), .alu_gnt(1'b1),
    .alu_ctrl(nb_ctrl), .alu_src1(nb_s1), .alu_src2(nb_s2),
    .alu_ret(nb_ret), .alu_carry(nb_carry), .dbg_state(nb_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one multiply; lat counts cycles from the start edge to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stalls, input bit busy_start, input bit flush_done,
                        output int lat, output int reqs);
    int grants;
    bit prev_stall;
    logic [W-1:0] ps1, ps2;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1; gnt = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1; reqs = 0; grants = 0; prev_stall = 1'b0;
    ps1 = '0; ps2 = '0;
    while (!done && lat < 100) begin
      if (prev_stall && alu_req) begin
        chk("stall_src1", {16'h0, alu_src1}, {16'h0, ps1});
        chk("stall_src2", {16'h0, alu_src2}, {16'h0, ps2});
      end
      prev_stall = 1'b0;
      if (busy_start && lat == 3) begin
        start = 1'b1; op_a = 16'hBEEF; op_b = 16'h0003;
      end else begin
        start = 1'b0;
      end
      if (alu_req) begin
        reqs++;
        if (stalls > 0 && ($urandom_range(0, 1) == 1 || grants == W - 1)) begin
          gnt = 1'b0; stalls--; prev_stall = 1'b1;
          ps1 = alu_src1; ps2 = alu_src2;
        end else begin
          gnt = 1'b1; grants++;
        end
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0; gnt = 1'b1;
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    if (flush_done) flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    int lat, reqs;
    bit seen;
    #2;
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_prod", {prod_hi, prod_lo}, 32'd0);
    chk("rst_req", {31'h0, alu_req}, 32'd0);
    chk("rst_srcs", {alu_src1, alu_src2}, 32'd0);
    chk("rst_state", {30'h0, dbg_state}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_op(16'd3, 16'd5, 0, 1'b0, 1'b0, lat, reqs);
    chk("m3x5_lat", lat, 32'd17);
    chk("m3x5_reqs", reqs, 32'd16);
    chk("m3x5_prod", {prod_hi, prod_lo}, 32'h0000_000F);
    chk("ctrl_add", {29'h0, alu_ctrl}, 32'd0);

    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0, 1'b0, lat, reqs);
    chk("mffff_prod", {prod_hi, prod_lo}, 32'hFFFE_0001);

    run_op(16'h1234, 16'h5678, 7, 1'b0, 1'b0, lat, reqs);
    chk("stall_lat", lat, 32'd24);
    chk("stall_prod", {prod_hi, prod_lo}, 32'h0626_0060);

    run_op(16'h0000, 16'hABCD, 0, 1'b0, 1'b0, lat, reqs);
    chk("byp_lat", lat, 32'd1);
    chk("byp_reqs", reqs, 32'd0);
    chk("byp_prod", {prod_hi, prod_lo}, 32'd0);

    @(negedge clk);
    op_a = 16'h0000; op_b = 16'hABCD; start_nb = 1'b1;
    @(negedge clk);
    start_nb = 1'b0; lat = 1;
    while (!nb_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("nobyp_lat", lat, 32'd17);
    @(negedge clk);
    chk("nobyp_prod", {nb_hi, nb_lo}, 32'd0);

    run_op(16'd3, 16'd5, 0, 1'b0, 1'b0, lat, reqs);
    chk("pre_flush_prod", {prod_hi, prod_lo}, 32'h0000_000F);
    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seen = 1'b0;
    repeat (4) begin
      seen = seen | done;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    seen = seen | done;
    chk("flush_no_done", {31'h0, seen}, 32'd0);
    chk("flush_busy", {31'h0, busy}, 32'd0);
    chk("flush_req", {31'h0, alu_req}, 32'd0);
    chk("flush_prod", {prod_hi, prod_lo}, 32'h0000_000F);

    run_op(16'd7, 16'd9, 0, 1'b0, 1'b0, lat, reqs);
    chk("m7x9_lat", lat, 32'd17);
    chk("m7x9_prod", {prod_hi, prod_lo}, 32'h0000_003F);

    run_op(16'd200, 16'd100, 0, 1'b1, 1'b0, lat, reqs);
    chk("busy_start_lat", lat, 32'd17);
    chk("busy_start_prod", {prod_hi, prod_lo}, 32'h0000_4E20);
    chk("busy_start_idle", {31'h0, busy}, 32'd0);

    run_op(16'h0011, 16'h0011, 0, 1'b0, 1'b1, lat, reqs);
    chk("flush_done_prod", {prod_hi, prod_lo}, 32'h0000_0121);

    @(negedge clk);
    op_a = 16'd2; op_b = 16'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_wins_busy", {31'h0, busy}, 32'd0);
    chk("flush_wins_prod", {prod_hi, prod_lo}, 32'h0000_0121);

    @(negedge clk);
    op_a = 16'h1111; op_b = 16'h0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", {31'h0, alu_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'd0);
    chk("arst_req", {31'h0, alu_req}, 32'd0);
    chk("arst_srcs", {alu_src1, alu_src2}, 32'd0);
    chk("arst_prod", {prod_hi, prod_lo}, 32'd0);
    chk("arst_done", {31'h0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'd3, 16'd5, 0, 1'b0, 1'b0, lat, reqs);
    chk("post_rst_prod", {prod_hi, prod_lo}, 32'h0000_000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
Multi-cycle unsigned 16x16->32 multiply sequencer built on the shared core ALU. It runs shift-and-add, issuing one ALU add per multiplier bit. It shares the ALU with the core through a req/gnt handshake and stalls whenever the grant is withheld. It sits beside the ALU in the execute stage and serves a MUL instruction via start/done.

Parameters:
WIDTH, 16, operand width; the product is 2*WIDTH. Only 16 is verified.
ZERO_BYPASS, 1, when 1 a zero operand skips the ALU entirely and completes in one cycle.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin multiply; sampled in IDLE only
flush  input  1  synchronous abort of an in-flight multiply
op_a  input  WIDTH  multiplicand
op_b  input  WIDTH  multiplier
busy  output  1  operation in flight (RUN or DONE)
done  output  1  one-cycle pulse; product valid
prod_hi  output  WIDTH  product upper half
prod_lo  output  WIDTH  product lower half
alu_req  output  1  request ALU for this cycle
alu_gnt  input  1  ALU granted this cycle (combinational from core arbiter)
alu_ctrl  output  3  ALU opcode; always 3'b000 (add)
alu_src1  output  WIDTH  ALU operand 1
alu_src2  output  WIDTH  ALU operand 2
alu_ret  input  WIDTH  ALU result, same cycle
alu_carry  input  1  ALU carry-out of the add, same cycle

Behaviour:
- Reset, asynchronous and immediate, including mid-operation:
  - state=IDLE; busy=0, done=0.
  - prod_hi=prod_lo=0.
  - alu_req=0, alu_ctrl=3'b000, alu_src1=alu_src2=0.
  - Internal registers acc, mq, mcand and cnt=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1: latch mcand=op_a, mq=op_b, acc=0, cnt=0.
  - If ZERO_BYPASS and (op_a==0 or op_b==0): set acc=mq=0 and go to DONE.
  - Otherwise go to RUN.
  - start=0: stay in IDLE.
- RUN, combinational outputs:
  - alu_req=1, alu_ctrl=000.
  - alu_src1=acc.
  - alu_src2 = mq[0] ? mcand : 0.
- RUN, on alu_gnt=1 (at the clock edge):
  - acc <= {alu_carry, alu_ret[WIDTH-1:1]}
  - mq <= {alu_ret[0], mq[WIDTH-1:1]}
  - cnt <= cnt+1
  - If cnt==WIDTH-1, go to DONE.
- RUN, on alu_gnt=0: all state holds; the request stays asserted with identical operands. No timeout.
- DONE, one cycle:
  - done=1, busy=1, alu_req=0.
  - prod_hi<=acc and prod_lo<=mq at the exit edge; go to IDLE.
- Product outputs:
  - Read prod_* from the cycle after done onward.
  - They hold their value until the next completed operation.
  - A flush or a start does not change them.
- When alu_req=0, alu_src1 and alu_src2 are driven 0.
- busy=1 in RUN and DONE only, so busy rises the cycle after start is accepted.
- start while busy: ignored, no queueing.
- flush, in RUN: go to IDLE next edge. No done, prod_* unchanged, alu_req drops next cycle.
- flush and start together in IDLE: flush wins; start is not accepted.
- flush in DONE: ignored; the result completes normally.
- Latency with alu_gnt held at 1: start sampled at edge T, RUN for cycles T+1..T+WIDTH, done at cycle T+WIDTH+1 (T+17 at WIDTH=16).
  - Each cycle with alu_gnt=0 adds one cycle.
  - Bypass latency: done at T+1.
- Arithmetic:
  - Unsigned only.
  - The ALU carry is the 17th accumulator bit, so no overflow is possible.
  - Result = op_a*op_b mod 2^32.
- Back-to-back: start may be asserted in the cycle after done (state IDLE) and is accepted.

Test Plan:
- 3 x 5, gnt=1 -> done exactly 17 cycles after the start edge; prod_hi=0x0000, prod_lo=0x000F; alu_req high 16 cycles.
- 0xFFFF x 0xFFFF, gnt=1 -> prod_hi=0xFFFE, prod_lo=0x0001 (exercises the carry path).
- 0x1234 x 0x5678 with gnt low for 7 random RUN cycles -> done at T+24; prod_hi=0x0626, prod_lo=0x0060; operands stable during stalls.
- 0 x 0xABCD, ZERO_BYPASS=1 -> done at T+1, product 0, alu_req never asserted. With ZERO_BYPASS=0 -> done at T+17, product 0.
- flush in the 5th RUN cycle after a prior result of 15 -> no done, busy low 1 cycle later, prod_lo stays 0x000F. Then start 7 x 9 -> 0x003F.
- rst pulsed mid-RUN -> all outputs 0 asynchronously. start asserted while busy -> ignored; the first result is still correct.
